// File: rtl/m_ext_frontend.sv
// Issue/sequencing front end for the M-extension unit: a counter-paced multiplier,
// control of an external iterative divider, and a one-entry cache of the last division.
module m_ext_frontend #(
  parameter int MUL_LAT      = 2,
  parameter bit DIV_CACHE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        flush,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] result,
  output logic        div_start,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  output logic [2:0]  div_funct3,
  input  logic        div_done,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder
);
  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_MUL, S_DIV_ISSUE, S_DIV_WAIT, S_DRAIN, S_DONE
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [31:0]   op_a, op_b;
  logic [2:0]    op_f3;
  logic          c_valid, c_unsigned;
  logic [31:0]   c_rs1, c_rs2, c_quot, c_rem;

  logic          accept, cache_hit, capture, cache_load;
  logic [31:0]   cap_val, mul_res, div_res;
  logic          a_sign, b_sign;
  logic signed [63:0] ext_a, ext_b, product;

  // Handshake: a request is taken in IDLE when req_valid=1 and flush=0; the EX stage
  // holds its inputs while busy=1 and advances in the cycle resp_valid=1 (busy=0).
  assign accept    = (state == S_IDLE) && req_valid && !flush;
  assign cache_hit = DIV_CACHE_EN && c_valid && (rs1 == c_rs1) && (rs2 == c_rs2)
                     && (funct3[0] == c_unsigned);

  assign div_dividend = op_a;
  assign div_divisor  = op_b;
  assign div_funct3   = op_f3;

  // mulh sign-extends both operands, mulhsu only A; low 64 bits of the 33x33 product suffice.
  assign a_sign  = ((op_f3[1:0] == 2'b01) || (op_f3[1:0] == 2'b10)) && op_a[31];
  assign b_sign  = (op_f3[1:0] == 2'b01) && op_b[31];
  assign ext_a   = {{32{a_sign}}, op_a};
  assign ext_b   = {{32{b_sign}}, op_b};
  assign product = ext_a * ext_b;
  assign mul_res = (op_f3[1:0] == 2'b00) ? product[31:0] : product[63:32];
  assign div_res = op_f3[1] ? div_remainder : div_quotient;

  always_comb begin
    state_n    = state;
    busy       = 1'b0;
    resp_valid = 1'b0;
    div_start  = 1'b0;
    capture    = 1'b0;
    cache_load = 1'b0;
    cap_val    = '0;
    case (state)
      S_IDLE: begin
        busy = req_valid && !flush;
        if (accept) begin
          if (!funct3[2]) begin
            state_n = S_MUL;
          end else if (cache_hit) begin
            state_n = S_DONE;
            capture = 1'b1;
            cap_val = funct3[1] ? c_rem : c_quot;
          end else begin
            state_n = S_DIV_ISSUE;
          end
        end
      end
      S_MUL: begin
        busy = 1'b1;
        if (flush) begin
          state_n = S_IDLE;
        end else if (cnt == '0) begin
          state_n = S_DONE;
          capture = 1'b1;
          cap_val = mul_res;
        end
      end
      S_DIV_ISSUE, S_DIV_WAIT: begin
        busy      = 1'b1;
        div_start = (state == S_DIV_ISSUE);
        if (div_done) begin
          if (flush) begin
            state_n = S_IDLE;
          end else begin
            state_n    = S_DONE;
            capture    = 1'b1;
            cache_load = 1'b1;
            cap_val    = div_res;
          end
        end else if (flush) begin
          // The divider is still running; wait it out so the next start finds it idle.
          state_n = S_DRAIN;
        end else begin
          state_n = S_DIV_WAIT;
        end
      end
      S_DRAIN: begin
        busy = req_valid;
        if (div_done) state_n = S_IDLE;
      end
      S_DONE: begin
        resp_valid = !flush;
        state_n    = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      result     <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_f3      <= '0;
      c_valid    <= 1'b0;
      c_unsigned <= 1'b0;
      c_rs1      <= '0;
      c_rs2      <= '0;
      c_quot     <= '0;
      c_rem      <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        op_a  <= rs1;
        op_b  <= rs2;
        op_f3 <= funct3;
        cnt   <= CW'(MUL_LAT - 1);
      end else if (state == S_MUL) begin
        cnt <= cnt - CW'(1);
      end
      if (capture) result <= cap_val;
      if (cache_load) begin
        c_valid    <= 1'b1;
        c_rs1      <= op_a;
        c_rs2      <= op_b;
        c_unsigned <= op_f3[0];
        c_quot     <= div_quotient;
        c_rem      <= div_remainder;
      end
    end
  end
endmodule

// File: tb/tb_m_ext_frontend.sv
// Bench for m_ext_frontend: a behavioural 32-cycle divider, directed scenarios and
// randomized operations checked against an arithmetic model with a last-division cache.
module tb_m_ext_frontend;
  localparam int MUL_LAT = 2;

  logic        clk = 1'b0, rst = 1'b0, req_valid = 1'b0, flush = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic        busy, resp_valid, div_start, div_done;
  logic [31:0] result, div_dividend, div_divisor, div_quotient, div_remainder;
  logic [2:0]  div_funct3;

  int n_checks = 0, n_fail = 0;

  logic        m_cv = 1'b0, m_cu = 1'b0;
  logic [31:0] m_c1 = '0, m_c2 = '0, m_cq = '0, m_cr = '0;

  logic        dv_busy = 1'b0;
  int          dv_cnt = 0;
  logic [63:0] dv_qr = '0;

  m_ext_frontend #(.MUL_LAT(MUL_LAT), .DIV_CACHE_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .flush(flush), .busy(busy), .resp_valid(resp_valid), .result(result),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_funct3(div_funct3), .div_done(div_done), .div_quotient(div_quotient),
    .div_remainder(div_remainder)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic is_special(input logic [31:0] a, b, input logic uns);
    return (b == 0) || (!uns && a == 32'h80000000 && b == 32'hFFFFFFFF);
  endfunction

  // {quotient, remainder} following the RISC-V division rules.
  function automatic logic [63:0] ref_div(input logic [31:0] a, b, input logic uns);
    int sa, sb;
    if (b == 0) return {32'hFFFFFFFF, a};
    if (uns) return {a / b, a % b};
    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h80000000, 32'h0};
    sa = a;
    sb = b;
    return {32'(sa / sb), 32'(sa % sb)};
  endfunction

  function automatic logic [31:0] ref_mul(input logic [2:0] f3, input logic [31:0] a, b);
    longint sp;
    logic [63:0] up;
    case (f3[1:0])
      2'b00: begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
      2'b01: begin sp = longint'($signed(a)) * longint'($signed(b)); return sp[63:32]; end
      2'b10: begin sp = longint'($signed(a)) * longint'({32'b0, b}); return sp[63:32]; end
      default: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
    endcase
  endfunction

  // Divider: answers in the start cycle for the special cases, else 33 cycles after start.
  always_comb begin
    div_done = 1'b0;
    div_quotient = '0;
    div_remainder = '0;
    if (div_start && is_special(div_dividend, div_divisor, div_funct3[0])) begin
      div_done = 1'b1;
      {div_quotient, div_remainder} = ref_div(div_dividend, div_divisor, div_funct3[0]);
    end else if (dv_busy && dv_cnt == 0) begin
      div_done = 1'b1;
      {div_quotient, div_remainder} = dv_qr;
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      dv_busy <= 1'b0;
    end else if (div_start && !is_special(div_dividend, div_divisor, div_funct3[0])) begin
      dv_busy <= 1'b1;
      dv_cnt  <= 32;
      dv_qr   <= ref_div(div_dividend, div_divisor, div_funct3[0]);
    end else if (dv_busy) begin
      if (dv_cnt == 0) dv_busy <= 1'b0;
      else dv_cnt <= dv_cnt - 1;
    end
  end

  // Expected latency/result/start count of one op; updates the model cache.
  task automatic model_op(input logic [2:0] f3, input logic [31:0] a, b,
                          output int lat, output logic [31:0] res, output int starts);
    logic [63:0] qr;
    if (!f3[2]) begin
      lat = 1 + MUL_LAT; res = ref_mul(f3, a, b); starts = 0;
    end else if (m_cv && a == m_c1 && b == m_c2 && f3[0] == m_cu) begin
      lat = 1; res = f3[1] ? m_cr : m_cq; starts = 0;
    end else begin
      qr = ref_div(a, b, f3[0]);
      lat = is_special(a, b, f3[0]) ? 2 : 35;
      res = f3[1] ? qr[31:0] : qr[63:32];
      starts = 1;
      m_cv = 1'b1; m_c1 = a; m_c2 = b; m_cu = f3[0]; m_cq = qr[63:32]; m_cr = qr[31:0];
    end
  endtask

  // Drives one request and observes latency, result, div_start pulses and busy gaps.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, b,
                       output int lat, output logic [31:0] res, output int starts,
                       output int start_cyc, output int busy_low, output int extra);
    lat = -1; res = '0; starts = 0; start_cyc = -1; busy_low = 0; extra = 0;
    @(negedge clk);
    req_valid = 1'b1; funct3 = f3; rs1 = a; rs2 = b;
    #1;
    if (!busy) busy_low++;
    if (div_start) starts++;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (div_start) begin starts++; start_cyc = i; end
      if (resp_valid) begin lat = i; res = result; break; end
      if (!busy) busy_low++;
    end
    req_valid = 1'b0;
    @(negedge clk);
    if (resp_valid || busy) extra++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b expected 0", busy); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset resp_valid: got %b expected 0", resp_valid); end
    n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset result: got %h expected 0", result); end
    n_checks++; if (div_start !== 1'b0) begin n_fail++; $display("FAIL reset div_start: got %b expected 0", div_start); end
    n_checks++; if ({div_dividend, div_divisor, div_funct3} !== 67'h0) begin n_fail++;
      $display("FAIL reset div operands: got %h %h %h expected 0", div_dividend, div_divisor, div_funct3); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul();
    logic [2:0]  f3s [4] = '{3'b000, 3'b001, 3'b011, 3'b010};
    logic [31:0] as  [4] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] bs  [4] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] exp [4] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
    int lat, st, sc, bl, ex, mlat, mst;
    logic [31:0] res, mres;
    for (int k = 0; k < 4; k++) begin
      model_op(f3s[k], as[k], bs[k], mlat, mres, mst);
      do_op(f3s[k], as[k], bs[k], lat, res, st, sc, bl, ex);
      n_checks++; if (res !== exp[k]) begin n_fail++; $display("FAIL mul%0d result: got %h expected %h", k, res, exp[k]); end
      n_checks++; if (lat !== 1 + MUL_LAT) begin n_fail++; $display("FAIL mul%0d latency: got %0d expected %0d", k, lat, 1 + MUL_LAT); end
      n_checks++; if (bl !== 0 || ex !== 0 || st !== 0) begin n_fail++;
        $display("FAIL mul%0d handshake: busy_low=%0d extra=%0d starts=%0d expected 0 0 0", k, bl, ex, st); end
    end
  endtask

  task automatic test_div_cache();
    int lat, st, sc, bl, ex, mlat, mst;
    logic [31:0] res, mres;
    model_op(3'b100, 32'hFFFFFFEC, 32'd3, mlat, mres, mst);
    do_op(3'b100, 32'hFFFFFFEC, 32'd3, lat, res, st, sc, bl, ex);
    n_checks++; if (res !== 32'hFFFFFFFA) begin n_fail++; $display("FAIL div result: got %h expected fffffffa", res); end
    n_checks++; if (lat !== 35) begin n_fail++; $display("FAIL div latency: got %0d expected 35", lat); end
    n_checks++; if (st !== 1 || sc !== 1) begin n_fail++; $display("FAIL div start: got %0d pulses at %0d expected 1 at 1", st, sc); end
    n_checks++; if (bl !== 0 || ex !== 0) begin n_fail++; $display("FAIL div handshake: busy_low=%0d extra=%0d expected 0 0", bl, ex); end
    model_op(3'b110, 32'hFFFFFFEC, 32'd3, mlat, mres, mst);
    do_op(3'b110, 32'hFFFFFFEC, 32'd3, lat, res, st, sc, bl, ex);
    n_checks++; if (res !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL rem hit result: got %h expected fffffffe", res); end
    n_checks++; if (lat !== 1 || st !== 0) begin n_fail++; $display("FAIL rem hit: latency %0d starts %0d expected 1 0", lat, st); end
    model_op(3'b111, 32'hFFFFFFEC, 32'd3, mlat, mres, mst);
    do_op(3'b111, 32'hFFFFFFEC, 32'd3, lat, res, st, sc, bl, ex);
    n_checks++; if (res !== 32'd2) begin n_fail++; $display("FAIL remu result: got %h expected 2", res); end
    n_checks++; if (lat !== 35 || st !== 1) begin n_fail++; $display("FAIL remu miss: latency %0d starts %0d expected 35 1", lat, st); end
  endtask

  task automatic test_div_special();
    int lat, st, sc, bl, ex, mlat, mst;
    logic [31:0] res, mres;
    model_op(3'b101, 32'h1234, 32'd0, mlat, mres, mst);
    do_op(3'b101, 32'h1234, 32'd0, lat, res, st, sc, bl, ex);
    n_checks++; if (res !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL divu0 result: got %h expected ffffffff", res); end
    n_checks++; if (lat !== 2 || st !== 1) begin n_fail++; $display("FAIL divu0: latency %0d starts %0d expected 2 1", lat, st); end
    model_op(3'b100, 32'h80000000, 32'hFFFFFFFF, mlat, mres, mst);
    do_op(3'b100, 32'h80000000, 32'hFFFFFFFF, lat, res, st, sc, bl, ex);
    n_checks++; if (res !== 32'h80000000) begin n_fail++; $display("FAIL div ovf result: got %h expected 80000000", res); end
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL div ovf latency: got %0d expected 2", lat); end
    model_op(3'b110, 32'h80000000, 32'hFFFFFFFF, mlat, mres, mst);
    do_op(3'b110, 32'h80000000, 32'hFFFFFFFF, lat, res, st, sc, bl, ex);
    n_checks++; if (res !== 32'h0) begin n_fail++; $display("FAIL rem ovf result: got %h expected 0", res); end
  endtask

  task automatic test_flush_mul();
    int seen = 0;
    @(negedge clk);
    req_valid = 1'b1; funct3 = 3'b000; rs1 = 32'd5; rs2 = 32'd6;
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1; if (resp_valid || busy) seen++;
      @(negedge clk);
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL flush mul: got %0d active cycles expected 0", seen); end
  endtask

  task automatic test_flush_div();
    int resp_at = -1, start_at = -1, nstart = 0, busy_low = 0;
    int lat, st, sc, bl, ex, mlat, mst;
    logic [31:0] res = '0, mres;
    @(negedge clk);
    req_valid = 1'b1; funct3 = 3'b100; rs1 = 32'd1000; rs2 = 32'd9;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i == 10) flush = 1'b1;
      if (i == 11) begin flush = 1'b0; funct3 = 3'b101; rs1 = 32'd100; rs2 = 32'd7; end
      #1;
      if (div_start && i >= 11) begin nstart++; start_at = i; end
      if (resp_valid) begin resp_at = i; res = result; break; end
      if (i >= 11 && !busy) busy_low++;
    end
    req_valid = 1'b0;
    // Drained divider finishes at +34, DIVU accepted at +35, issued at +36, answers 35 later.
    n_checks++; if (resp_at !== 70) begin n_fail++; $display("FAIL flush div resp cycle: got %0d expected 70", resp_at); end
    n_checks++; if (res !== 32'd14) begin n_fail++; $display("FAIL flush divu result: got %h expected 0000000e", res); end
    n_checks++; if (nstart !== 1 || start_at !== 36) begin n_fail++;
      $display("FAIL flush divu start: got %0d pulses at %0d expected 1 at 36", nstart, start_at); end
    n_checks++; if (busy_low !== 0) begin n_fail++; $display("FAIL flush drain busy: got %0d low cycles expected 0", busy_low); end
    model_op(3'b101, 32'd100, 32'd7, mlat, mres, mst);
    @(negedge clk);
    model_op(3'b110, 32'd1000, 32'd9, mlat, mres, mst);
    do_op(3'b110, 32'd1000, 32'd9, lat, res, st, sc, bl, ex);
    n_checks++; if (res !== 32'd1 || lat !== 35 || st !== 1) begin n_fail++;
      $display("FAIL rem after flush: result %h latency %0d starts %0d expected 1 35 1", res, lat, st); end
  endtask

  task automatic test_reset_mid();
    int seen = 0, lat, st, sc, bl, ex, mlat, mst;
    logic [31:0] res, mres;
    model_op(3'b100, 32'd55, 32'd6, mlat, mres, mst);
    do_op(3'b100, 32'd55, 32'd6, lat, res, st, sc, bl, ex);
    n_checks++; if (res !== 32'd9 || lat !== 35) begin n_fail++;
      $display("FAIL div 55/6: result %h latency %0d expected 9 35", res, lat); end
    @(negedge clk);
    req_valid = 1'b1; funct3 = 3'b100; rs1 = 32'd77; rs2 = 32'd5;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || resp_valid !== 1'b0 || div_start !== 1'b0) begin n_fail++;
      $display("FAIL mid reset: busy %b resp_valid %b div_start %b expected 0 0 0", busy, resp_valid, div_start); end
    rst = 1'b1;
    m_cv = 1'b0;
    repeat (3) begin @(negedge clk); if (resp_valid) seen++; end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL mid reset resp: got %0d strobes expected 0", seen); end
    model_op(3'b110, 32'd55, 32'd6, mlat, mres, mst);
    do_op(3'b110, 32'd55, 32'd6, lat, res, st, sc, bl, ex);
    n_checks++; if (res !== 32'd1 || lat !== 35 || st !== 1) begin n_fail++;
      $display("FAIL rem after reset: result %h latency %0d starts %0d expected 1 35 1", res, lat, st); end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [31:0] a = '0, b = '0, res, mres;
    logic [2:0] f3;
    int lat, st, sc, bl, ex, mlat, mst;
    for (int k = 0; k < 40; k++) begin
      if (k == 0 || $urandom_range(0, 2) != 0) begin a = pick(); b = pick(); end
      f3 = 3'($urandom_range(0, 7));
      model_op(f3, a, b, mlat, mres, mst);
      do_op(f3, a, b, lat, res, st, sc, bl, ex);
      n_checks++; if (res !== mres) begin n_fail++;
        $display("FAIL rand%0d f3=%0d a=%h b=%h result: got %h expected %h", k, f3, a, b, res, mres); end
      n_checks++; if (lat !== mlat) begin n_fail++;
        $display("FAIL rand%0d f3=%0d a=%h b=%h latency: got %0d expected %0d", k, f3, a, b, lat, mlat); end
      n_checks++; if (st !== mst || (mst == 1 && sc !== 1)) begin n_fail++;
        $display("FAIL rand%0d div_start: got %0d pulses at %0d expected %0d", k, st, sc, mst); end
      n_checks++; if (bl !== 0 || ex !== 0) begin n_fail++;
        $display("FAIL rand%0d handshake: busy_low=%0d extra=%0d expected 0 0", k, bl, ex); end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div_cache();
    test_div_special();
    test_flush_mul();
    test_flush_div();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/m_ext_frontend.md
Name: m_ext_frontend

Overview:
- Issue/sequencing front end for the EX-stage M-extension unit.
- Accepts a MUL*/DIV*/REM* request from the EX stage and stalls the pipeline while the request is in flight.
- Computes multiplies in an internal fixed-latency pipeline.
- Drives the iterative divider (start/operands/funct3, consumes done/quotient/remainder) and caches the last division so a DIV/REM pair on the same operands completes in one cycle.

Parameters:
- MUL_LAT, 2, multiplier pipeline depth in cycles (>=1).
- DIV_CACHE_EN, 1, 1 enables the last-division result cache; 0 forces every division through the divider.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Synchronous, active-low: the block is reset on the clk edge at which rst=0.
- req_valid  in  1  EX-stage M-op valid. Held stable while busy=1.
- funct3  in  3  m_funct3_t: mul=000, mulh=001, mulhsu=010, mulhu=011, div=100, divu=101, rem=110, remu=111.
- rs1  in  32  operand A / dividend.
- rs2  in  32  operand B / divisor.
- flush  in  1  kill the in-flight op; no response is produced.
- busy  out  1  stall request to the pipeline.
- resp_valid  out  1  one-cycle result strobe.
- result  out  32  M-op result; valid while resp_valid=1.
- div_start  out  1  divider start pulse.
- div_dividend  out  32  divider dividend, held from DIV_ISSUE through capture.
- div_divisor  out  32  divider divisor, held likewise.
- div_funct3  out  3  divider funct3, held likewise.
- div_done  in  1  divider completion. May be high in the same cycle as div_start for divide-by-zero or signed overflow.
- div_quotient  in  32  valid only while div_done=1.
- div_remainder  in  32  valid only while div_done=1.

Behaviour:
- Reset (rst=0 at an edge): state=IDLE, cache_valid=0, resp_valid=0, result=0, div_start=0, div_* operand regs=0.
- The divider's own reset is driven from the same rst at integration.
- Request latch: on acceptance, rs1, rs2 and funct3 are latched internally.
- Outputs div_dividend, div_divisor and div_funct3 come from those latches and never from live inputs.
- States: IDLE, MUL, DIV_ISSUE, DIV_WAIT, DRAIN, DONE.
- IDLE:
  - Accepts when req_valid=1 and flush=0.
  - funct3[2]=0 -> MUL, counter=MUL_LAT-1.
  - funct3[2]=1 with cache hit -> DONE. Hit requires DIV_CACHE_EN, cache_valid, rs1==c_rs1, rs2==c_rs2, funct3[0]==c_unsigned. Result = funct3[1] ? c_rem : c_quot.
  - funct3[2]=1 otherwise -> DIV_ISSUE.
- MUL:
  - Operand extension: a = {(mulh|mulhsu) ? rs1[31] : 0, rs1}; b = {mulh ? rs2[31] : 0, rs2}.
  - Signed 33x33 product, 66 bits.
  - Counter decrements each cycle; at 0, capture result = (funct3==mul) ? p[31:0] : p[63:32], then -> DONE.
- DIV_ISSUE: div_start=1 for exactly this cycle.
  - div_done=1 in this cycle -> capture and go to DONE.
  - Otherwise -> DIV_WAIT.
- DIV_WAIT: div_start=0. On div_done:
  - result = funct3[1] ? div_remainder : div_quotient.
  - Cache loads rs1, rs2, funct3[0], quotient, remainder; cache_valid=1.
  - -> DONE.
- DONE: resp_valid=1 and result driven for exactly one cycle, then -> IDLE.
  - A req_valid seen in the following IDLE cycle is a new instruction.
- busy:
  - 1 in MUL, DIV_ISSUE and DIV_WAIT.
  - 1 in IDLE when req_valid=1 and flush=0.
  - 1 in DRAIN when req_valid=1.
  - 0 in DONE.
- Latency, accept at cycle t:
  - MUL: resp_valid at t+1+MUL_LAT.
  - Cache hit: t+1.
  - Divide-by-zero / signed overflow: t+2.
  - Normal division: t+35 (divider start at t+1, 32 shift cycles, done at t+34).
- Flush (highest priority after reset):
  - IDLE: no accept.
  - MUL: -> IDLE.
  - DONE: resp_valid forced 0, -> IDLE.
  - DIV_ISSUE with div_done=1: -> IDLE.
  - DIV_ISSUE with div_done=0, or DIV_WAIT: -> DRAIN.
- DRAIN:
  - div_start=0; no requests accepted.
  - On div_done: discard the result, do not update the cache, -> IDLE.
  - The next division therefore never issues into a busy divider.
- Reset mid-operation: immediate return to IDLE with cache cleared. No resp_valid.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD at t -> busy high t..t+2, resp_valid only at t+3, result=0xFFFFFFEB.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV rs1=0xFFFFFFEC (-20), rs2=3 at t:
  - single div_start pulse at t+1, result 0xFFFFFFFA at t+35.
  - Next, REM on the same operands -> 0xFFFFFFFE one cycle after accept, no div_start.
  - Then REMU on the same operands -> cache miss, div_start pulses.
- DIVU rs1=0x1234, rs2=0 -> 0xFFFFFFFF at t+2.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at t+2.
- REM 0x80000000 / 0xFFFFFFFF -> 0.
- Flush at t+10 of a DIV:
  - no resp_valid; block enters DRAIN.
  - DIVU 100/7 held from t+11 has busy=1 and is not accepted until after div_done.
  - Result 14. A REM on the flushed operands then misses the cache.
- rst=0 for one cycle during DIV_WAIT, then a REM on the completed pair:
  - next cycle state IDLE, resp_valid=0, busy=0 (req_valid low).
  - The REM misses the cache.
